bus_arbiter: RTL and testbench

// Two-master, one-slave arbiter for the start/done memory bus used by the VRAM and memory units.

---
 rtl/bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_bus_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master, one-slave arbiter for the start/done memory bus: round-robin
// on ties, registered grant and slave request, and a watchdog that aborts hung transfers.
module bus_arbiter #(
  parameter int                ADDR_W    = 27,
  parameter int                DATA_W    = 32,
  parameter int                TIMEOUT   = 1023,
  parameter logic [DATA_W-1:0] TIMEOUT_Q = 32'hDEADBEEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  // master 0 (CPU)
  input  logic              m0_start,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_q,
  // master 1 (DMA / loader)
  input  logic              m1_start,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_q,
  // slave port
  output logic              s_start,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_data,
  input  logic              s_done,
  input  logic [DATA_W-1:0] s_q,
  // status
  output logic [1:0]        o_grant,
  output logic              o_timeout,
  output logic              dbg_state
);

  // Handshake: a master request is mk_start held high until its one-cycle mk_done;
  // the slave sees s_start held high with stable s_* until it pulses s_done.

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state, state_n;
  logic              last, last_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              s_start_n, s_we_n;
  logic [ADDR_W-1:0] s_addr_n;
  logic [DATA_W-1:0] s_data_n;
  logic [1:0]        grant_n;
  logic              m0_done_n, m1_done_n, timeout_n;
  logic [DATA_W-1:0] m0_q_n, m1_q_n;
  logic              elig0, elig1, pick1, expired;
  logic [DATA_W-1:0] ret_q;

  assign dbg_state = (state == BUSY);

  always_comb begin
    // A master whose done is high this cycle is excluded so a held start
    // cannot win the slot twice in a row.
    elig0   = m0_start & ~m0_done;
    elig1   = m1_start & ~m1_done;
    pick1   = elig1 & (~elig0 | ~last);
    expired = (TIMEOUT != 0) && (cnt == TMAX);
    ret_q   = s_done ? s_q : TIMEOUT_Q;

    state_n   = state;
    last_n    = last;
    cnt_n     = cnt;
    s_start_n = s_start;
    s_we_n    = s_we;
    s_addr_n  = s_addr;
    s_data_n  = s_data;
    grant_n   = o_grant;
    m0_done_n = 1'b0;
    m1_done_n = 1'b0;
    m0_q_n    = '0;
    m1_q_n    = '0;
    timeout_n = 1'b0;

    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          state_n   = BUSY;
          last_n    = pick1;
          grant_n   = pick1 ? 2'b10 : 2'b01;
          s_start_n = 1'b1;
          cnt_n     = '0;
          s_we_n    = pick1 ? m1_we   : m0_we;
          s_addr_n  = pick1 ? m1_addr : m0_addr;
          s_data_n  = pick1 ? m1_data : m0_data;
        end
      end
      BUSY: begin
        if (s_done || expired) begin
          // s_done takes priority over an expiry in the same cycle.
          state_n   = IDLE;
          s_start_n = 1'b0;
          grant_n   = 2'b00;
          timeout_n = ~s_done;
          if (o_grant[1]) begin
            m1_done_n = 1'b1;
            m1_q_n    = ret_q;
          end else begin
            m0_done_n = 1'b1;
            m0_q_n    = ret_q;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      s_start   <= 1'b0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_data    <= '0;
      o_grant   <= 2'b00;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      m0_q      <= '0;
      m1_q      <= '0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      cnt       <= cnt_n;
      s_start   <= s_start_n;
      s_we      <= s_we_n;
      s_addr    <= s_addr_n;
      s_data    <= s_data_n;
      o_grant   <= grant_n;
      m0_done   <= m0_done_n;
      m1_done   <= m1_done_n;
      m0_q      <= m0_q_n;
      m1_q      <= m1_q_n;
      o_timeout <= timeout_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios, the bench acting as
// masters and slave, with a queue of expected completions.
module tb_bus_arbiter;

  localparam int          ADDR_W  = 27;
  localparam int          DATA_W  = 32;
  localparam int          TIMEOUT = 8;
  localparam logic [31:0] TQ      = 32'hDEADBEEF;
  localparam int          SB_W    = 35;  // {m1_done, m0_done, o_timeout, q}

  logic              i_clk, i_reset;
  logic              m0_start, m0_we, m0_done;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_data, m0_q;
  logic              m1_start, m1_we, m1_done;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_data, m1_q;
  logic              s_start, s_we, s_done;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data, s_q;
  logic [1:0]        o_grant;
  logic              o_timeout, dbg_state;

  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] e, got;
  int n_checks = 0;
  int n_pass   = 0;

  bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TIMEOUT_Q(TQ)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .m0_start(m0_start), .m0_we(m0_we), .m0_addr(m0_addr), .m0_data(m0_data),
    .m0_done(m0_done), .m0_q(m0_q),
    .m1_start(m1_start), .m1_we(m1_we), .m1_addr(m1_addr), .m1_data(m1_data),
    .m1_done(m1_done), .m1_q(m1_q),
    .s_start(s_start), .s_we(s_we), .s_addr(s_addr), .s_data(s_data),
    .s_done(s_done), .s_q(s_q),
    .o_grant(o_grant), .o_timeout(o_timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_start = 0; m0_we = 0; m0_addr = '0; m0_data = '0;
    m1_start = 0; m1_we = 0; m1_addr = '0; m1_data = '0;
    s_done = 0; s_q = '0;
  endtask

  // Slave model: waits (bounded) for s_start, stalls lat cycles, then pulses
  // s_done with q. Returns just after the edge that produces mk_done.
  task automatic slave_respond(input int lat, input logic [31:0] q);
    for (int i = 0; i < 50 && !s_start; i++) tick();
    if (!s_start) begin
      n_checks++;
      $display("FAIL slave_wait: s_start=%b required 1 within 50 cycles", s_start);
      return;
    end
    repeat (lat) tick();
    s_done = 1'b1; s_q = q;
    tick();
    s_done = 1'b0; s_q = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_reset = 1'b1;
    idle_inputs();
    tick(); tick();
    n_checks++;
    if ({s_start, s_we, s_addr, s_data, o_grant, o_timeout, dbg_state} !== '0)
      $display("FAIL reset_slave_side: got %h required 0",
               {s_start, s_we, s_addr, s_data, o_grant, o_timeout, dbg_state});
    else n_pass++;
    n_checks++;
    if ({m0_done, m0_q, m1_done, m1_q} !== '0)
      $display("FAIL reset_master_side: got %h required 0", {m0_done, m0_q, m1_done, m1_q});
    else n_pass++;
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    m0_we = 1; m0_addr = 4; m0_data = 37; m0_start = 1;
    tick();
    n_checks++;
    if ({s_start, s_we, s_addr, s_data, o_grant} !== {1'b1, 1'b1, 27'd4, 32'd37, 2'b01})
      $display("FAIL write_latch: got s_start=%b s_we=%b s_addr=%0d s_data=%0d grant=%b required 1 1 4 37 01",
               s_start, s_we, s_addr, s_data, o_grant);
    else n_pass++;
    exp_q.push_back({2'b01, 1'b0, 32'h55});
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin m0_data = 32'hFF; m0_addr = 99; end
      n_checks++;
      if ({s_start, o_grant, s_addr, s_data} !== {1'b1, 2'b01, 27'd4, 32'd37})
        $display("FAIL write_hold: cycle %0d got s_start=%b grant=%b s_addr=%0d s_data=%0d required 1 01 4 37",
                 i, s_start, o_grant, s_addr, s_data);
      else n_pass++;
      tick();
    end
    s_done = 1; s_q = 32'h55;
    tick();
    s_done = 0; s_q = '0;
    got = {m1_done, m0_done, o_timeout, m0_q | m1_q};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL write_done: got %h required %h", got, e);
    else n_pass++;
    n_checks++;
    if ({s_start, o_grant} !== 3'b000)
      $display("FAIL write_release: got s_start=%b grant=%b required 0 00", s_start, o_grant);
    else n_pass++;
    m0_start = 0; m0_we = 0;
    tick();
    n_checks++;
    if ({m0_done, m0_q} !== '0)
      $display("FAIL done_one_cycle: got m0_done=%b m0_q=%h required 0 0", m0_done, m0_q);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    i_reset = 1; tick(); i_reset = 0; tick();
    // both after reset: m0 wins the first tie
    m0_addr = 10; m1_addr = 20; m0_start = 1; m1_start = 1;
    tick();
    n_checks++;
    if ({o_grant, s_addr} !== {2'b01, 27'd10})
      $display("FAIL rr_first: got grant=%b s_addr=%0d required 01 10", o_grant, s_addr);
    else n_pass++;
    exp_q.push_back({2'b01, 1'b0, 32'd17});
    slave_respond(1, 32'(s_addr) + 32'd7);
    got = {m1_done, m0_done, o_timeout, m0_q | m1_q};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL rr_m0_done: got %h required %h", got, e);
    else n_pass++;
    m0_start = 0;
    tick();
    n_checks++;
    if ({o_grant, s_addr} !== {2'b10, 27'd20})
      $display("FAIL rr_second: got grant=%b s_addr=%0d required 10 20", o_grant, s_addr);
    else n_pass++;
    exp_q.push_back({2'b10, 1'b0, 32'd27});
    slave_respond(2, 32'(s_addr) + 32'd7);
    got = {m1_done, m0_done, o_timeout, m0_q | m1_q};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL rr_m1_done: got %h required %h", got, e);
    else n_pass++;
    m1_start = 0;
    tick();
    // m0 alone, then a tie: m1 must win because m0 was served last
    m0_addr = 11; m0_start = 1;
    tick();
    exp_q.push_back({2'b01, 1'b0, 32'd18});
    slave_respond(1, 32'(s_addr) + 32'd7);
    got = {m1_done, m0_done, o_timeout, m0_q | m1_q};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL rr_m0_solo: got %h required %h", got, e);
    else n_pass++;
    m0_start = 0;
    tick();
    m0_addr = 12; m1_addr = 21; m0_start = 1; m1_start = 1;
    tick();
    n_checks++;
    if ({o_grant, s_addr} !== {2'b10, 27'd21})
      $display("FAIL rr_alternate: got grant=%b s_addr=%0d required 10 21", o_grant, s_addr);
    else n_pass++;
    exp_q.push_back({2'b10, 1'b0, 32'd28});
    slave_respond(1, 32'(s_addr) + 32'd7);
    m1_start = 0;
    got = {m1_done, m0_done, o_timeout, m0_q | m1_q};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL rr_alt_m1: got %h required %h", got, e);
    else n_pass++;
    tick();
    exp_q.push_back({2'b01, 1'b0, 32'd19});
    slave_respond(1, 32'(s_addr) + 32'd7);
    got = {m1_done, m0_done, o_timeout, m0_q | m1_q};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL rr_alt_m0: got %h required %h", got, e);
    else n_pass++;
    m0_start = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    m0_addr = 27'h30; m0_start = 1;
    tick();
    m1_addr = 27'h40; m1_start = 1;
    exp_q.push_back({2'b01, 1'b0, 32'd1});
    slave_respond(1, 32'd1);
    got = {m1_done, m0_done, o_timeout, m0_q | m1_q};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL b2b_m0_first: got %h required %h", got, e);
    else n_pass++;
    tick();
    n_checks++;
    if ({o_grant, s_addr} !== {2'b10, 27'h40})
      $display("FAIL b2b_m1_next: got grant=%b s_addr=%h required 10 40", o_grant, s_addr);
    else n_pass++;
    exp_q.push_back({2'b10, 1'b0, 32'd2});
    slave_respond(1, 32'd2);
    got = {m1_done, m0_done, o_timeout, m0_q | m1_q};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL b2b_m1_done: got %h required %h", got, e);
    else n_pass++;
    m1_start = 0;
    tick();
    n_checks++;
    if ({o_grant, s_addr} !== {2'b01, 27'h30})
      $display("FAIL b2b_m0_again: got grant=%b s_addr=%h required 01 30", o_grant, s_addr);
    else n_pass++;
    exp_q.push_back({2'b01, 1'b0, 32'd3});
    slave_respond(1, 32'd3);
    got = {m1_done, m0_done, o_timeout, m0_q | m1_q};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL b2b_m0_done: got %h required %h", got, e);
    else n_pass++;
    m0_start = 0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    m0_addr = 27'h50; m0_start = 1;
    tick();
    exp_q.push_back({2'b01, 1'b1, TQ});
    n = 0;
    while (!(m0_done || m1_done) && n < 20) begin
      tick();
      n++;
    end
    // TIMEOUT=8: abort lands 8 edges after the grant edge (9th counting the grant)
    n_checks++;
    if (n != 8) $display("FAIL timeout_latency: got %0d edges after grant required 8", n);
    else n_pass++;
    got = {m1_done, m0_done, o_timeout, m0_q | m1_q};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL timeout_done: got %h required %h", got, e);
    else n_pass++;
    n_checks++;
    if ({s_start, o_grant} !== 3'b000)
      $display("FAIL timeout_release: got s_start=%b grant=%b required 0 00", s_start, o_grant);
    else n_pass++;
    m0_start = 0;
    tick();
    n_checks++;
    if (o_timeout !== 1'b0) $display("FAIL timeout_pulse: got o_timeout=%b required 0", o_timeout);
    else n_pass++;
    s_done = 1; s_q = 32'h1234;
    tick();
    s_done = 0; s_q = '0;
    n_checks++;
    if ({m0_done, m1_done, m0_q, m1_q, dbg_state} !== '0)
      $display("FAIL late_done_ignored: got m0_done=%b m1_done=%b busy=%b required 0 0 0",
               m0_done, m1_done, dbg_state);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    m0_addr = 27'h60; m0_start = 1;
    tick();
    tick(); tick();
    i_reset = 1;
    #1;
    n_checks++;
    if ({s_start, s_we, s_addr, s_data, o_grant, o_timeout, m0_done, m0_q, m1_done, m1_q, dbg_state} !== '0)
      $display("FAIL async_reset: got s_start=%b grant=%b s_addr=%h busy=%b required all 0",
               s_start, o_grant, s_addr, dbg_state);
    else n_pass++;
    m0_start = 0;
    tick();
    i_reset = 0;
    s_done = 1; s_q = 32'hABCD;
    tick();
    s_done = 0; s_q = '0;
    n_checks++;
    if ({m0_done, m1_done, o_grant} !== 4'b0000)
      $display("FAIL stray_done: got m0_done=%b m1_done=%b grant=%b required 0 0 00",
               m0_done, m1_done, o_grant);
    else n_pass++;
    m1_addr = 27'h70; m1_start = 1;
    tick();
    n_checks++;
    if ({o_grant, s_start, s_addr} !== {2'b10, 1'b1, 27'h70})
      $display("FAIL post_reset_grant: got grant=%b s_start=%b s_addr=%h required 10 1 70",
               o_grant, s_start, s_addr);
    else n_pass++;
    exp_q.push_back({2'b10, 1'b0, 32'h77});
    slave_respond(1, 32'h77);
    got = {m1_done, m0_done, o_timeout, m0_q | m1_q};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL post_reset_done: got %h required %h", got, e);
    else n_pass++;
    m1_start = 0;
    tick();
  endtask

  task automatic test_done_at_timeout();
    m1_addr = 27'h80; m1_start = 1;
    tick();
    exp_q.push_back({2'b10, 1'b0, 32'hCAFE});
    // s_done sampled on the same edge the watchdog would fire
    slave_respond(7, 32'hCAFE);
    got = {m1_done, m0_done, o_timeout, m0_q | m1_q};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL done_beats_timeout: got %h required %h", got, e);
    else n_pass++;
    m1_start = 0;
    tick();
    n_checks++;
    if ({o_timeout, m1_done} !== 2'b00)
      $display("FAIL no_late_timeout: got o_timeout=%b m1_done=%b required 0 0", o_timeout, m1_done);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    test_done_at_timeout();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
